state_1ms_param_loader: RTL and testbench

// - Host-side writer for the 1 ms state sequencer's parameter-load interface (load / loadchoice / datain / start).
// - Host writes 16-bit parameters into a shadow file at any time while idle, then issues commit.
// - On commit the block replays every slot written since the last commit into the sequencer, one load burst per slot, in ascending slot order.
// - After the last slot it optionally fires the sequencer start pulse.

---
 rtl/state_1ms_param_loader_if.sv | 29 ++
 rtl/state_1ms_param_loader.sv | 181 ++++++++++++++++++
 tb/tb_state_1ms_param_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/state_1ms_param_loader_if.sv
// Host and sequencer signal bundle for the 1 ms state parameter loader.
// master: host side (drives writes/commit, observes status and sequencer lines).
// slave : the loader itself.
interface state_1ms_param_loader_if;
    // host side
    logic        host_wr;
    logic [3:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_commit;
    logic        host_arm;
    logic        busy;
    logic        done;
    logic        wr_err;
    // sequencer side
    logic        load;
    logic [3:0]  loadchoice;
    logic [15:0] datain;
    logic        state_1ms_start;

    modport master (
        output host_wr, host_addr, host_wdata, host_commit, host_arm,
        input  busy, done, wr_err, load, loadchoice, datain, state_1ms_start
    );

    modport slave (
        input  host_wr, host_addr, host_wdata, host_commit, host_arm,
        output busy, done, wr_err, load, loadchoice, datain, state_1ms_start
    );
endinterface

// File: rtl/state_1ms_param_loader.sv
// Shadow parameter file with commit-triggered replay into the 1 ms state
// sequencer's load interface, followed by an optional start pulse.
//
// state | meaning
// IDLE  | accept host writes into the shadow file; wait for commit
// SCAN  | test dirty[ptr]; one cycle per slot
// LOAD  | load strobe high, loadchoice/datain = slot ptr, LOAD_CYCLES cycles
// GAP   | load low, loadchoice/datain held, GAP_CYCLES cycles
// START | one cycle, start pulse if armed at commit
// FIN   | one cycle, done pulse, busy low; back to IDLE
module state_1ms_param_loader #(
    parameter int NUM_SLOTS   = 16,
    parameter int LOAD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                     clk_sys,
    input  logic                     loader_rst_n,
    state_1ms_param_loader_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    // The timer only has to reach (max burst length - 1).
    localparam int CNT_MAX = (LOAD_CYCLES > GAP_CYCLES) ? LOAD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_SLOT = 4'(NUM_SLOTS - 1);
    localparam logic [4:0]       SLOT_LIM  = 5'(NUM_SLOTS);

    logic [2:0]       state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arm_q, arm_d;
    logic [15:0]      dirty_q, dirty_d;
    logic [15:0]      shadow_q [16];
    logic [15:0]      shadow_d [16];
    logic [3:0]       loadchoice_q, loadchoice_d;
    logic [15:0]      datain_q, datain_d;
    logic             wr_err_q, wr_err_d;

    logic addr_valid;
    logic in_idle;
    logic wr_ok;

    assign addr_valid = ({1'b0, bus.host_addr} < SLOT_LIM);
    assign in_idle    = (state_q == S_IDLE);
    assign wr_ok      = bus.host_wr && addr_valid && in_idle;

    // Next-state, shadow-file update and error detection.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        arm_d        = arm_q;
        dirty_d      = dirty_q;
        shadow_d     = shadow_q;
        loadchoice_d = loadchoice_q;
        datain_d     = datain_q;
        wr_err_d     = 1'b0;

        // Rejected writes and late commits share one error pulse.
        if (bus.host_wr && !wr_ok) begin
            wr_err_d = 1'b1;
        end
        if (bus.host_commit && !in_idle) begin
            wr_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Write lands before the commit so it joins this replay.
                if (wr_ok) begin
                    shadow_d[bus.host_addr] = bus.host_wdata;
                    dirty_d[bus.host_addr]  = 1'b1;
                end
                if (bus.host_commit) begin
                    state_d = S_SCAN;
                    ptr_d   = 4'd0;
                    arm_d   = bus.host_arm;
                end
            end

            S_SCAN: begin
                if (dirty_q[ptr_q]) begin
                    state_d         = S_LOAD;
                    dirty_d[ptr_q]  = 1'b0;
                    cnt_d           = LOAD_INIT;
                    loadchoice_d    = ptr_q;
                    datain_d        = shadow_q[ptr_q];
                end else if (ptr_q == LAST_SLOT) begin
                    state_d = S_START;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end

            S_LOAD: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_INIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == '0) begin
                    if (ptr_q == LAST_SLOT) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_SCAN;
                        ptr_d   = ptr_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_START: begin
                state_d = S_FIN;
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, shadow file and output holding registers; reset wipes everything,
    // including pending dirty bits, so an interrupted replay is abandoned.
    always_ff @(posedge clk_sys) begin
        if (!loader_rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= 4'd0;
            cnt_q        <= '0;
            arm_q        <= 1'b0;
            dirty_q      <= 16'd0;
            loadchoice_q <= 4'd0;
            datain_q     <= 16'd0;
            wr_err_q     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= 16'd0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            arm_q        <= arm_d;
            dirty_q      <= dirty_d;
            loadchoice_q <= loadchoice_d;
            datain_q     <= datain_d;
            wr_err_q     <= wr_err_d;
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Status and strobes are pure decodes of the registered state, so they
    // drop on the same edge that reset forces the FSM to IDLE.
    assign bus.busy            = (state_q == S_SCAN) || (state_q == S_LOAD) ||
                                 (state_q == S_GAP)  || (state_q == S_START);
    assign bus.done            = (state_q == S_FIN);
    assign bus.load            = (state_q == S_LOAD);
    assign bus.state_1ms_start = (state_q == S_START) && arm_q;
    assign bus.wr_err          = wr_err_q;
    assign bus.loadchoice      = loadchoice_q;
    assign bus.datain          = datain_q;

endmodule

// File: tb/tb_state_1ms_param_loader.sv
// Bench for state_1ms_param_loader: trace-based reference model for the
// 16-slot instance plus directed literal expectations, and a small 8-slot
// instance for address-range boundaries.
module tb_state_1ms_param_loader;

    localparam int NS = 16;
    localparam int LC = 2;
    localparam int GC = 2;

    logic clk_sys = 1'b0;
    logic loader_rst_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    state_1ms_param_loader_if bus ();
    state_1ms_param_loader_if bus8 ();

    state_1ms_param_loader #(.NUM_SLOTS(16), .LOAD_CYCLES(LC), .GAP_CYCLES(GC)) dut (
        .clk_sys(clk_sys), .loader_rst_n(loader_rst_n), .bus(bus));

    state_1ms_param_loader #(.NUM_SLOTS(8), .LOAD_CYCLES(LC), .GAP_CYCLES(GC)) dut8 (
        .clk_sys(clk_sys), .loader_rst_n(loader_rst_n), .bus(bus8));

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        load;
        logic        start;
        logic [3:0]  lc;
        logic [15:0] din;
    } exp_t;

    typedef struct packed {
        logic [3:0]  lc;
        logic [15:0] din;
    } ld_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model (16-slot instance) ----------------
    logic [15:0] m_shadow [NS];
    logic        m_dirty  [NS];
    logic [3:0]  m_lc;
    logic [15:0] m_din;
    exp_t        exp_q[$];
    exp_t        exp_cur;
    logic        exp_err;
    logic        model_ok = 1'b0;
    int          pos_cnt = 0;

    // A replay is: one scan cycle per slot, plus a load burst and a gap for
    // each dirty slot, then a start cycle and a done cycle.
    function automatic void build_trace(input logic arm);
        exp_t        e;
        logic [3:0]  clc;
        logic [15:0] cdin;
        clc  = m_lc;
        cdin = m_din;
        for (int s = 0; s < NS; s++) begin
            e = '0; e.busy = 1'b1; e.lc = clc; e.din = cdin;
            exp_q.push_back(e);
            if (m_dirty[s]) begin
                m_dirty[s] = 1'b0;
                clc  = 4'(s);
                cdin = m_shadow[s];
                e.lc = clc; e.din = cdin;
                e.load = 1'b1;
                for (int k = 0; k < LC; k++) exp_q.push_back(e);
                e.load = 1'b0;
                for (int k = 0; k < GC; k++) exp_q.push_back(e);
            end
        end
        e = '0; e.busy = 1'b1; e.start = arm; e.lc = clc; e.din = cdin;
        exp_q.push_back(e);
        e = '0; e.done = 1'b1; e.lc = clc; e.din = cdin;
        exp_q.push_back(e);
        m_lc  = clc;
        m_din = cdin;
    endfunction

    always @(posedge clk_sys) begin
        logic err;
        logic idle;
        pos_cnt++;
        if (!loader_rst_n) begin
            for (int i = 0; i < NS; i++) begin
                m_shadow[i] = 16'd0;
                m_dirty[i]  = 1'b0;
            end
            exp_q.delete();
            m_lc     = 4'd0;
            m_din    = 16'd0;
            exp_cur  = '0;
            exp_err  = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            idle = !exp_cur.busy && !exp_cur.done;
            err  = 1'b0;
            if (bus.host_wr) begin
                if (idle && int'(bus.host_addr) < NS) begin
                    m_shadow[bus.host_addr] = bus.host_wdata;
                    m_dirty[bus.host_addr]  = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            if (bus.host_commit) begin
                if (!idle) err = 1'b1;
                else build_trace(bus.host_arm);
            end
            if (exp_q.size() > 0) begin
                exp_cur = exp_q.pop_front();
            end else begin
                exp_cur = '0;
                exp_cur.lc  = m_lc;
                exp_cur.din = m_din;
            end
            exp_err = err;
        end
    end

    // ---------------- compare + monitors ----------------
    int  n_load, n_burst, n_start, n_err, n_done, done_edge, start_edge;
    ld_t ld_q[$];
    logic prev_load = 1'b0;
    int  n_load8, n_err8, n_done8, done_edge8;
    ld_t ld8_q[$];

    always @(negedge clk_sys) begin
        if (model_ok) begin
            chk("busy",       32'(bus.busy),            32'(exp_cur.busy));
            chk("done",       32'(bus.done),            32'(exp_cur.done));
            chk("load",       32'(bus.load),            32'(exp_cur.load));
            chk("start",      32'(bus.state_1ms_start), 32'(exp_cur.start));
            chk("loadchoice", 32'(bus.loadchoice),      32'(exp_cur.lc));
            chk("datain",     32'(bus.datain),          32'(exp_cur.din));
            chk("wr_err",     32'(bus.wr_err),          32'(exp_err));
        end
        if (bus.load === 1'b1) begin
            n_load++;
            if (!prev_load) n_burst++;
            ld_q.push_back('{lc: bus.loadchoice, din: bus.datain});
        end
        prev_load = (bus.load === 1'b1);
        if (bus.state_1ms_start === 1'b1) begin n_start++; start_edge = pos_cnt; end
        if (bus.wr_err === 1'b1) n_err++;
        if (bus.done === 1'b1) begin n_done++; done_edge = pos_cnt; end
        if (bus8.load === 1'b1) begin
            n_load8++;
            ld8_q.push_back('{lc: bus8.loadchoice, din: bus8.datain});
        end
        if (bus8.wr_err === 1'b1) n_err8++;
        if (bus8.done === 1'b1) begin n_done8++; done_edge8 = pos_cnt; end
    end

    // ---------------- stimulus helpers ----------------
    int commit_edge, commit_edge8;

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic clr_mon();
        n_load = 0; n_burst = 0; n_start = 0; n_err = 0; n_done = 0;
        done_edge = 0; start_edge = 0; ld_q.delete();
        n_load8 = 0; n_err8 = 0; n_done8 = 0; done_edge8 = 0; ld8_q.delete();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.host_wr = 1'b1; bus.host_addr = a; bus.host_wdata = d;
        tick();
        bus.host_wr = 1'b0;
    endtask

    task automatic commit(input logic arm);
        bus.host_commit = 1'b1; bus.host_arm = arm;
        commit_edge = pos_cnt + 1;
        tick();
        bus.host_commit = 1'b0; bus.host_arm = 1'b0;
    endtask

    task automatic wr8(input logic [3:0] a, input logic [15:0] d);
        bus8.host_wr = 1'b1; bus8.host_addr = a; bus8.host_wdata = d;
        tick();
        bus8.host_wr = 1'b0;
    endtask

    task automatic commit8(input logic arm);
        bus8.host_commit = 1'b1; bus8.host_arm = arm;
        commit_edge8 = pos_cnt + 1;
        tick();
        bus8.host_commit = 1'b0; bus8.host_arm = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int b = 0;
        while (n_done == 0 && b < budget) begin tick(); b++; end
        if (n_done == 0) begin
            checks++; errors++;
            $display("FAIL %s timeout actual=no_done expected=done within %0d cycles", name, budget);
        end
        tick();
    endtask

    task automatic wait_done8(input string name, input int budget);
        int b = 0;
        while (n_done8 == 0 && b < budget) begin tick(); b++; end
        if (n_done8 == 0) begin
            checks++; errors++;
            $display("FAIL %s timeout actual=no_done expected=done within %0d cycles", name, budget);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.host_commit = 1'b0; bus.host_arm = 1'b0;
        bus8.host_wr = 1'b0; bus8.host_addr = '0; bus8.host_wdata = '0;
        bus8.host_commit = 1'b0; bus8.host_arm = 1'b0;
        clr_mon();
        loader_rst_n = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_done",   32'(bus.done), 0);
        chk("rst_load",   32'(bus.load), 0);
        chk("rst_lc",     32'(bus.loadchoice), 0);
        chk("rst_din",    32'(bus.datain), 0);
        chk("rst_start",  32'(bus.state_1ms_start), 0);
        chk("rst_wr_err", 32'(bus.wr_err), 0);
        loader_rst_n = 1'b1;
        repeat (2) tick();

        // two slots, armed
        clr_mon();
        wr(4'd3, 16'h1234);
        wr(4'd7, 16'hABCD);
        commit(1'b1);
        wait_done("t1_done", 100);
        chk("t1_nload", n_load, 4);
        chk("t1_nburst", n_burst, 2);
        if (ld_q.size() == 4) begin
            chk("t1_ld0", 32'(ld_q[0]), 32'({4'd3, 16'h1234}));
            chk("t1_ld1", 32'(ld_q[1]), 32'({4'd3, 16'h1234}));
            chk("t1_ld2", 32'(ld_q[2]), 32'({4'd7, 16'hABCD}));
            chk("t1_ld3", 32'(ld_q[3]), 32'({4'd7, 16'hABCD}));
        end
        chk("t1_nstart", n_start, 1);
        chk("t1_ndone", n_done, 1);
        chk("t1_start_to_done", done_edge - start_edge, 1);
        // 16 scan + 2*(2+2) + start + fin = 26 cycles
        chk("t1_done_cycle", done_edge - commit_edge + 1, 26);

        // empty commit, unarmed
        clr_mon();
        commit(1'b0);
        wait_done("t2_done", 100);
        chk("t2_nload", n_load, 0);
        chk("t2_nstart", n_start, 0);
        chk("t2_done_cycle", done_edge - commit_edge + 1, 18);

        // rewrite same slot: one burst, last value
        clr_mon();
        wr(4'd5, 16'h0001);
        wr(4'd5, 16'h0002);
        commit(1'b0);
        wait_done("t3_done", 100);
        chk("t3_nburst", n_burst, 1);
        chk("t3_nload", n_load, 2);
        if (ld_q.size() == 2) begin
            chk("t3_ld0", 32'(ld_q[0]), 32'({4'd5, 16'h0002}));
            chk("t3_ld1", 32'(ld_q[1]), 32'({4'd5, 16'h0002}));
        end

        // write during busy is rejected; commit during busy too
        clr_mon();
        wr(4'd9, 16'h0042);
        commit(1'b1);
        repeat (3) tick();
        wr(4'd2, 16'hFFFF);
        tick();
        chk("t4_err_wr", n_err, 1);
        bus.host_commit = 1'b1; bus.host_arm = 1'b1;
        tick();
        bus.host_commit = 1'b0; bus.host_arm = 1'b0;
        tick();
        chk("t4_err_commit", n_err, 2);
        wait_done("t4_done", 100);
        chk("t4_ndone", n_done, 1);
        clr_mon();
        commit(1'b0);
        wait_done("t4b_done", 100);
        chk("t4b_nload", n_load, 0);
        chk("t4b_lc_held", 32'(bus.loadchoice), 32'd9);

        // write to the last slot in the commit cycle
        clr_mon();
        bus.host_wr = 1'b1; bus.host_addr = 4'hF; bus.host_wdata = 16'hBEEF;
        bus.host_commit = 1'b1; bus.host_arm = 1'b0;
        commit_edge = pos_cnt + 1;
        tick();
        bus.host_wr = 1'b0; bus.host_commit = 1'b0;
        wait_done("t5_done", 100);
        chk("t5_nload", n_load, 2);
        if (ld_q.size() == 2) chk("t5_ld0", 32'(ld_q[0]), 32'({4'hF, 16'hBEEF}));
        chk("t5_nstart", n_start, 0);
        chk("t5_err", n_err, 0);
        chk("t5_done_cycle", done_edge - commit_edge + 1, 22);

        // 8-slot instance: out-of-range address, then the top valid slot
        clr_mon();
        wr8(4'hF, 16'h7777);
        tick();
        chk("t6_err8", n_err8, 1);
        commit8(1'b0);
        wait_done8("t6_done8", 60);
        chk("t6_nload8", n_load8, 0);
        chk("t6_done_cycle8", done_edge8 - commit_edge8 + 1, 10);
        clr_mon();
        wr8(4'd7, 16'h0777);
        commit8(1'b0);
        wait_done8("t6b_done8", 60);
        chk("t6b_nload8", n_load8, 2);
        if (ld8_q.size() == 2) chk("t6b_ld8", 32'(ld8_q[1]), 32'({4'd7, 16'h0777}));
        chk("t6b_done_cycle8", done_edge8 - commit_edge8 + 1, 14);
        chk("t6b_err8", n_err8, 0);

        // reset during the second load cycle
        clr_mon();
        wr(4'd4, 16'h5555);
        wr(4'd11, 16'h6666);
        commit(1'b1);
        begin
            int b = 0;
            while (bus.load !== 1'b1 && b < 40) begin tick(); b++; end
        end
        chk("t7_saw_load", 32'(bus.load), 1);
        tick();
        chk("t7_second_load", 32'(bus.load), 1);
        loader_rst_n = 1'b0;
        tick();
        chk("t7_rst_load", 32'(bus.load), 0);
        chk("t7_rst_busy", 32'(bus.busy), 0);
        chk("t7_rst_start", 32'(bus.state_1ms_start), 0);
        loader_rst_n = 1'b1;
        repeat (30) tick();
        chk("t7_no_done", n_done, 0);
        clr_mon();
        commit(1'b0);
        wait_done("t7b_done", 100);
        chk("t7b_nload", n_load, 0);
        chk("t7b_done_cycle", done_edge - commit_edge + 1, 18);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
